// File: rtl/rx_pkt_deframer.sv
// rtl/rx_pkt_deframer.sv - sync-framed radio byte stream to 12-bit payload words.
// Optional trailing XOR checksum byte when RX_DEFRAMER_CHECKSUM_EN is defined.
module rx_pkt_deframer #(
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter int          PAYLOAD_BYTES = 120,
   parameter logic [15:0] LINE_WORDS    = 16'h0050,
   parameter logic [15:0] MAX_ADD       = 16'h9600,
   parameter int          TIMEOUT       = 1024
) (
   input  logic        Cclk,
   input  logic        rst,
   input  logic [7:0]  InByte,
   input  logic        InByteValid,
   output logic [15:0] RxAdd,
   output logic        RxAddValid,
   output logic [11:0] RxData,
   output logic        RxValid,
   output logic        PktOk,
   output logic        PktErr
);

`ifdef RX_DEFRAMER_CHECKSUM_EN
   typedef enum logic [2:0] {HUNT, ADDR_HI, ADDR_LO, PAYLOAD, CSUM} state_t;
`else
   typedef enum logic [2:0] {HUNT, ADDR_HI, ADDR_LO, PAYLOAD} state_t;
`endif

   state_t      state_q, state_d;
   logic [7:0]  addr_hi_q, addr_hi_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [1:0]  phase_q, phase_d;
   logic [7:0]  b0_q, b0_d;
   logic [3:0]  nib_q, nib_d;
   logic [9:0]  idle_q, idle_d;
   logic [15:0] rx_add_q, rx_add_d;
   logic        rx_add_valid_q, rx_add_valid_d;
   logic [11:0] rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        pkt_ok_q, pkt_ok_d;
   logic        pkt_err_q, pkt_err_d;
   logic        ok_pend_q, ok_pend_d;
`ifdef RX_DEFRAMER_CHECKSUM_EN
   logic [7:0]  acc_q, acc_d;
`endif

   logic [15:0] addr_w;
   logic        addr_ok;
   logic        last_byte;
   logic        timeout_hit;

   assign addr_w      = {addr_hi_q, InByte};
   assign addr_ok     = (addr_w < MAX_ADD) && ((addr_w % LINE_WORDS) == 16'd0);
   assign last_byte   = (cnt_q == 7'(PAYLOAD_BYTES - 1));
   assign timeout_hit = (idle_q == 10'(TIMEOUT - 1));

   always_ff @(posedge Cclk) begin
      if (rst) begin
         state_q        <= HUNT;
         addr_hi_q      <= 8'h00;
         cnt_q          <= 7'd0;
         phase_q        <= 2'd0;
         b0_q           <= 8'h00;
         nib_q          <= 4'h0;
         idle_q         <= 10'd0;
         rx_add_q       <= 16'h0000;
         rx_add_valid_q <= 1'b0;
         rx_data_q      <= 12'h000;
         rx_valid_q     <= 1'b0;
         pkt_ok_q       <= 1'b0;
         pkt_err_q      <= 1'b0;
         ok_pend_q      <= 1'b0;
`ifdef RX_DEFRAMER_CHECKSUM_EN
         acc_q          <= 8'h00;
`endif
      end else begin
         state_q        <= state_d;
         addr_hi_q      <= addr_hi_d;
         cnt_q          <= cnt_d;
         phase_q        <= phase_d;
         b0_q           <= b0_d;
         nib_q          <= nib_d;
         idle_q         <= idle_d;
         rx_add_q       <= rx_add_d;
         rx_add_valid_q <= rx_add_valid_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         pkt_ok_q       <= pkt_ok_d;
         pkt_err_q      <= pkt_err_d;
         ok_pend_q      <= ok_pend_d;
`ifdef RX_DEFRAMER_CHECKSUM_EN
         acc_q          <= acc_d;
`endif
      end
   end

   always_comb begin
      state_d        = state_q;
      addr_hi_d      = addr_hi_q;
      cnt_d          = cnt_q;
      phase_d        = phase_q;
      b0_d           = b0_q;
      nib_d          = nib_q;
      rx_add_d       = rx_add_q;
      rx_add_valid_d = 1'b0;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      // PktOk trails the final word by one cycle so the two never coincide.
      pkt_ok_d       = ok_pend_q;
      pkt_err_d      = 1'b0;
      ok_pend_d      = 1'b0;
`ifdef RX_DEFRAMER_CHECKSUM_EN
      acc_d          = acc_q;
`endif
      if (InByteValid || (state_q == HUNT)) begin
         idle_d = 10'd0;
      end else begin
         idle_d = idle_q + 10'd1;
      end

      if (InByteValid) begin
         case (state_q)
            HUNT: begin
               if (InByte == SYNC_BYTE) begin
                  state_d = ADDR_HI;
`ifdef RX_DEFRAMER_CHECKSUM_EN
                  acc_d   = 8'h00;
`endif
               end
            end
            ADDR_HI: begin
               addr_hi_d = InByte;
               state_d   = ADDR_LO;
`ifdef RX_DEFRAMER_CHECKSUM_EN
               acc_d     = acc_q ^ InByte;
`endif
            end
            ADDR_LO: begin
`ifdef RX_DEFRAMER_CHECKSUM_EN
               acc_d = acc_q ^ InByte;
`endif
               if (addr_ok) begin
                  rx_add_d       = addr_w;
                  rx_add_valid_d = 1'b1;
                  cnt_d          = 7'd0;
                  phase_d        = 2'd0;
                  state_d        = PAYLOAD;
               end else begin
                  pkt_err_d = 1'b1;
                  state_d   = HUNT;
               end
            end
            PAYLOAD: begin
`ifdef RX_DEFRAMER_CHECKSUM_EN
               acc_d = acc_q ^ InByte;
`endif
               cnt_d = cnt_q + 7'd1;
               case (phase_q)
                  2'd0: begin
                     b0_d    = InByte;
                     phase_d = 2'd1;
                  end
                  2'd1: begin
                     rx_data_d  = {b0_q, InByte[7:4]};
                     rx_valid_d = 1'b1;
                     nib_d      = InByte[3:0];
                     phase_d    = 2'd2;
                  end
                  default: begin
                     rx_data_d  = {nib_q, InByte};
                     rx_valid_d = 1'b1;
                     phase_d    = 2'd0;
                  end
               endcase
               if (last_byte) begin
`ifdef RX_DEFRAMER_CHECKSUM_EN
                  state_d   = CSUM;
`else
                  state_d   = HUNT;
                  ok_pend_d = 1'b1;
`endif
               end
            end
`ifdef RX_DEFRAMER_CHECKSUM_EN
            CSUM: begin
               if (InByte == acc_q) begin
                  pkt_ok_d = 1'b1;
               end else begin
                  pkt_err_d = 1'b1;
               end
               state_d = HUNT;
            end
`endif
            default: state_d = HUNT;
         endcase
      end else if ((state_q != HUNT) && timeout_hit) begin
         // Any partial triplet held in b0_q/nib_q is simply abandoned.
         state_d   = HUNT;
         pkt_err_d = 1'b1;
         idle_d    = 10'd0;
      end
   end

   assign RxAdd      = rx_add_q;
   assign RxAddValid = rx_add_valid_q;
   assign RxData     = rx_data_q;
   assign RxValid    = rx_valid_q;
   assign PktOk      = pkt_ok_q;
   assign PktErr     = pkt_err_q;

endmodule

// File: tb/tb_rx_pkt_deframer.sv
// tb/tb_rx_pkt_deframer.sv - directed self-checking bench for rx_pkt_deframer.
module tb_rx_pkt_deframer;

   logic        Cclk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  InByte = 8'h00;
   logic        InByteValid = 1'b0;
   logic [15:0] RxAdd;
   logic        RxAddValid;
   logic [11:0] RxData;
   logic        RxValid;
   logic        PktOk;
   logic        PktErr;

   rx_pkt_deframer dut (
      .Cclk        (Cclk),
      .rst         (rst),
      .InByte      (InByte),
      .InByteValid (InByteValid),
      .RxAdd       (RxAdd),
      .RxAddValid  (RxAddValid),
      .RxData      (RxData),
      .RxValid     (RxValid),
      .PktOk       (PktOk),
      .PktErr      (PktErr)
   );

   always #5 Cclk = ~Cclk;

   int          checks = 0;
   int          errors = 0;
   int          n_add = 0;
   int          n_ok = 0;
   int          n_err = 0;
   int          n_multi = 0;
   logic [15:0] last_add = 16'h0000;
   logic [11:0] words[$];

   always @(negedge Cclk) begin
      if (RxAddValid) begin
         n_add    <= n_add + 1;
         last_add <= RxAdd;
      end
      if (RxValid) words.push_back(RxData);
      if (PktOk)  n_ok  <= n_ok + 1;
      if (PktErr) n_err <= n_err + 1;
      if ((int'(RxAddValid) + int'(RxValid) + int'(PktOk) + int'(PktErr)) > 1)
         n_multi <= n_multi + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Payload byte i carries the value i; words derived by hand from triplets.
   function automatic logic [11:0] exp_word(input int k);
      logic [7:0] b0, b1, b2;
      b0 = 8'(3 * (k / 2));
      b1 = 8'(3 * (k / 2) + 1);
      b2 = 8'(3 * (k / 2) + 2);
      return (k % 2 == 0) ? {b0, b1[7:4]} : {b1[3:0], b2};
   endfunction

   function automatic logic [7:0] exp_csum(input logic [7:0] hi, input logic [7:0] lo);
      logic [7:0] x;
      x = hi ^ lo;
      for (int i = 0; i < 120; i++) x = x ^ 8'(i);
      return x;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(posedge Cclk);
      #1;
      InByte      = b;
      InByteValid = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Cclk);
         #1;
         InByteValid = 1'b0;
      end
   endtask

   task automatic send_hdr(input logic [7:0] hi, input logic [7:0] lo);
      send_byte(8'hA5);
      send_byte(hi);
      send_byte(lo);
   endtask

   task automatic send_payload(input int n);
      for (int i = 0; i < n; i++) send_byte(8'(i));
   endtask

   task automatic send_pkt(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] flip);
      send_hdr(hi, lo);
      send_payload(120);
`ifdef RX_DEFRAMER_CHECKSUM_EN
      send_byte(exp_csum(hi, lo) ^ flip);
`else
      if (flip != 8'h00) send_byte(8'h00);
`endif
      idle(4);
   endtask

   task automatic check_words(input string tag, input int start, input int n);
      int avail;
      avail = words.size() - start;
      check({tag, "_count"}, 32'(avail), 32'(n));
      for (int k = 0; k < n && k < avail; k++)
         check({tag, "_word"}, 32'(words[start + k]), 32'(exp_word(k)));
   endtask

   int s_add, s_ok, s_err, s_w, n_idle;
   logic seen;

   initial begin
      // Reset state
      idle(3);
      check("rst_rxadd", 32'(RxAdd), 32'h0);
      check("rst_rxdata", 32'(RxData), 32'h0);
      check("rst_addvalid", 32'(RxAddValid), 32'h0);
      check("rst_rxvalid", 32'(RxValid), 32'h0);
      check("rst_pktok", 32'(PktOk), 32'h0);
      check("rst_pkterr", 32'(PktErr), 32'h0);
      rst = 1'b0;
      idle(2);

      // Back-to-back packet at 0x0050
      s_add = n_add; s_ok = n_ok; s_err = n_err; s_w = words.size();
      send_hdr(8'h00, 8'h50);
      send_payload(120);
`ifdef RX_DEFRAMER_CHECKSUM_EN
      send_byte(8'h50);
      idle(1);
      check("basic_ok_after_csum", 32'(PktOk), 32'h1);
`else
      idle(1);
      check("basic_last_rxvalid", 32'(RxValid), 32'h1);
      check("basic_ok_not_with_word", 32'(PktOk), 32'h0);
      idle(1);
      check("basic_ok_next", 32'(PktOk), 32'h1);
`endif
      idle(3);
      check("basic_addcnt", 32'(n_add - s_add), 32'd1);
      check("basic_rxadd", 32'(last_add), 32'h0050);
      check("basic_first_word", 32'(words[s_w]), 32'h000);
      check("basic_second_word", 32'(words[s_w + 1]), 32'h102);
      check_words("basic", s_w, 80);
      check("basic_okcnt", 32'(n_ok - s_ok), 32'd1);
      check("basic_errcnt", 32'(n_err - s_err), 32'd0);

      // Address at MAX_ADD rejected, then next packet accepted
      s_add = n_add; s_err = n_err;
      send_hdr(8'h96, 8'h00);
      idle(1);
      check("maxadd_err_pulse", 32'(PktErr), 32'h1);
      check("maxadd_no_addvalid", 32'(RxAddValid), 32'h0);
      idle(2);
      check("maxadd_addcnt", 32'(n_add - s_add), 32'd0);
      check("maxadd_errcnt", 32'(n_err - s_err), 32'd1);

      s_err = n_err;
      send_hdr(8'h00, 8'h51);
      idle(3);
      check("unaligned_errcnt", 32'(n_err - s_err), 32'd1);
      check("unaligned_addcnt", 32'(n_add - s_add), 32'd0);

      s_add = n_add; s_ok = n_ok; s_w = words.size();
      send_pkt(8'h00, 8'hA0, 8'h00);
      check("next_addcnt", 32'(n_add - s_add), 32'd1);
      check("next_rxadd", 32'(last_add), 32'h00A0);
      check("next_okcnt", 32'(n_ok - s_ok), 32'd1);
      check("next_wordcnt", 32'(words.size() - s_w), 32'd80);

      // Highest valid line address
      s_add = n_add; s_ok = n_ok; s_err = n_err;
      send_pkt(8'h95, 8'hB0, 8'h00);
      check("top_rxadd", 32'(last_add), 32'h95B0);
      check("top_okcnt", 32'(n_ok - s_ok), 32'd1);
      check("top_errcnt", 32'(n_err - s_err), 32'd0);

      // Timeout after 40 payload bytes
      s_add = n_add; s_ok = n_ok; s_err = n_err; s_w = words.size();
      send_hdr(8'h00, 8'h50);
      send_payload(40);
      idle(1);
      n_idle = 0;
      seen = 1'b0;
      while (n_idle < 1100 && !seen) begin
         @(posedge Cclk);
         #1;
         n_idle++;
         if (PktErr) seen = 1'b1;
      end
      check("tmo_idle_cycles", 32'(n_idle), 32'd1024);
      idle(2);
      check("tmo_errcnt", 32'(n_err - s_err), 32'd1);
      check("tmo_okcnt", 32'(n_ok - s_ok), 32'd0);
      check_words("tmo", s_w, 26);
      check("tmo_rxdata_held", 32'(RxData), 32'(exp_word(25)));

      // Junk before sync
      s_add = n_add; s_ok = n_ok; s_err = n_err; s_w = words.size();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h5A);
      send_pkt(8'h00, 8'h50, 8'h00);
      check("junk_addcnt", 32'(n_add - s_add), 32'd1);
      check("junk_rxadd", 32'(last_add), 32'h0050);
      check_words("junk", s_w, 80);
      check("junk_okcnt", 32'(n_ok - s_ok), 32'd1);
      check("junk_errcnt", 32'(n_err - s_err), 32'd0);

`ifdef RX_DEFRAMER_CHECKSUM_EN
      // Corrupted checksum byte
      s_ok = n_ok; s_err = n_err; s_w = words.size();
      send_pkt(8'h00, 8'h50, 8'h01);
      check("badcsum_okcnt", 32'(n_ok - s_ok), 32'd0);
      check("badcsum_errcnt", 32'(n_err - s_err), 32'd1);
      check("badcsum_wordcnt", 32'(words.size() - s_w), 32'd80);
`endif

      // Reset at payload byte 60, then a clean packet at 0x0000
      s_add = n_add; s_ok = n_ok; s_err = n_err; s_w = words.size();
      send_hdr(8'h00, 8'h50);
      send_payload(60);
      @(posedge Cclk);
      #1;
      InByte = 8'd60;
      rst    = 1'b1;
      @(posedge Cclk);
      #1;
      rst         = 1'b0;
      InByteValid = 1'b0;
      check("midrst_rxdata", 32'(RxData), 32'h0);
      check("midrst_rxadd", 32'(RxAdd), 32'h0);
      check("midrst_rxvalid", 32'(RxValid), 32'h0);
      idle(3);
      check("midrst_wordcnt", 32'(words.size() - s_w), 32'd40);
      check("midrst_okcnt", 32'(n_ok - s_ok), 32'd0);
      check("midrst_errcnt", 32'(n_err - s_err), 32'd0);

      s_add = n_add; s_ok = n_ok; s_err = n_err; s_w = words.size();
      send_pkt(8'h00, 8'h00, 8'h00);
      check("postrst_addcnt", 32'(n_add - s_add), 32'd1);
      check("postrst_rxadd", 32'(last_add), 32'h0000);
      check_words("postrst", s_w, 80);
      check("postrst_okcnt", 32'(n_ok - s_ok), 32'd1);
      check("postrst_errcnt", 32'(n_err - s_err), 32'd0);

      check("pulse_overlap", 32'(n_multi), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_pkt_deframer.md
RX_PKT_DEFRAMER -- requirements
Module: rx_pkt_deframer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SYNC_BYTE, 8'hA5, packet start marker.
- PAYLOAD_BYTES, 120, payload bytes per packet (80 12-bit words).
- LINE_WORDS, 16'h0050, words per line; valid addresses are multiples of this.
- MAX_ADD, 16'h9600, first invalid address.
- TIMEOUT, 1024, idle Cclk cycles allowed between bytes mid-packet.

REQ-002 Ports (name, direction, width, meaning), one per line:
- Cclk, in, 1, the only clock; one clock, all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- InByte, in, 8, received byte from one radio lane.
- InByteValid, in, 1, InByte accepted this cycle.
- RxAdd, out, 16, line start word address.
- RxAddValid, out, 1, one-cycle pulse, RxAdd valid.
- RxData, out, 12, payload word.
- RxValid, out, 1, one-cycle pulse, RxData valid.
- PktOk, out, 1, one-cycle pulse, packet completed and accepted.
- PktErr, out, 1, one-cycle pulse, packet aborted or rejected.

Function
REQ-003 FSM states: HUNT, ADDR_HI, ADDR_LO, PAYLOAD, CSUM; the state changes only on a cycle with InByteValid, except for timeout.
REQ-004 HUNT: InByteValid with InByte==SYNC_BYTE -> ADDR_HI; any other byte is discarded and HUNT is kept.
REQ-005 ADDR_HI latches the byte as address[15:8] -> ADDR_LO; ADDR_LO latches address[7:0].
REQ-006 Address check at ADDR_LO: the address is valid if it is < MAX_ADD and (address mod LINE_WORDS)==0.
- Valid: -> PAYLOAD, with RxAdd=address and RxAddValid=1 on the next cycle.
- Invalid: -> HUNT, with PktErr=1 on the next cycle and no RxAddValid.
REQ-007 PAYLOAD unpacks each byte triplet b0,b1,b2 into two words:
- word0={b0,b1[7:4]}, RxValid pulses the cycle after b1 is accepted.
- word1={b1[3:0],b2}, RxValid pulses the cycle after b2 is accepted.
REQ-008 A byte counter (7 bits) counts 0..PAYLOAD_BYTES-1; it clears on entry to PAYLOAD.
REQ-009 PAYLOAD exit after the last payload byte (count==PAYLOAD_BYTES-1): -> CSUM when the checksum is enabled, otherwise -> HUNT with PktOk on the next cycle.
REQ-010 Each packet produces exactly 80 RxValid pulses, never 2 in consecutive-byte gaps shorter than 1 cycle; RxData holds its value between pulses.
REQ-011 Timeout: a 10-bit idle counter resets on every InByteValid and counts while the state is not HUNT. Reaching TIMEOUT-1 -> HUNT, with PktErr on the next cycle.
REQ-012 Timeout discards a partial triplet: no RxValid is issued for it, and already-issued words are not retracted.
REQ-013 In states other than HUNT, SYNC_BYTE is treated as data; there is no resync mid-packet.
REQ-014 At most one of RxAddValid, RxValid, PktOk, PktErr pulses per cycle, except that the final RxValid and PktOk are ordered word first, PktOk one cycle later.
REQ-015 InByteValid may be asserted every cycle; the block never stalls and has no back-pressure.

Reset
REQ-016 When rst=1 at a Cclk edge, the following clear on that edge:
- state -> HUNT;
- counters, checksum accumulator and triplet phase -> 0;
- RxAdd=16'h0000, RxData=12'h000;
- RxAddValid, RxValid, PktOk, PktErr = 0.
REQ-017 Reset mid-packet: no further outputs for that packet; the first byte after reset deasserts is evaluated in HUNT.

Configuration
REQ-018 Macro RX_DEFRAMER_CHECKSUM_EN, when defined:
- Accumulate the XOR of the address bytes and all payload bytes.
- CSUM compares the received byte against the accumulator: match -> PktOk next cycle, mismatch -> PktErr next cycle; both -> HUNT.
REQ-019 When RX_DEFRAMER_CHECKSUM_EN is undefined:
- The CSUM state and accumulator are absent.
- The packet ends after the payload, with PktOk per REQ-009.
- PktErr arises only from REQ-006 and REQ-011.

Verification
REQ-020 Back-to-back bytes A5,00,50, 120 bytes 0x00..0x77, checksum -> RxAddValid with RxAdd=0x0050, 80 RxValid, first word 0x000, second word 0x102, then PktOk.
REQ-021 Header A5,96,00 -> PktErr one cycle after the last address byte; no RxAddValid; the next A5 packet is accepted.
REQ-022 Valid header then 40 payload bytes then 1024 idle cycles -> PktErr, 26 RxValid only, state HUNT.
REQ-023 With CHECKSUM_EN, a packet with a checksum byte XOR 0x01 -> PktErr, no PktOk, all 80 RxValid still issued.
REQ-024 rst asserted for 1 cycle at payload byte 60, then a full valid packet at address 0x0000 -> exactly one RxAddValid (0x0000), 80 RxValid, one PktOk.
REQ-025 Leading junk bytes 00,FF,5A before A5 -> ignored; the packet decodes as in REQ-020.
